de1_blinker_input_pio: RTL and testbench

- Avalon-MM slave input PIO: the read-side counterpart of the board's output PIO.
- Samples asynchronous board inputs (keys/switches), synchronises and debounces them, then detects edges into a sticky capture register.
- Raises a level interrupt to the Nios II when any unmasked captured edge is pending.
- Sits on the system interconnect beside the output PIOs; software reads the port value, masks interrupts and clears captured edges.

---
 rtl/de1_blinker_pio_pkg.sv | 34 +++
 rtl/pio_debounce_bit.sv | 65 ++++++
 rtl/de1_blinker_input_pio.sv | 101 ++++++++++
 tb/tb_de1_blinker_input_pio.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/de1_blinker_pio_pkg.sv
// Shared definitions for the DE1 blinker PIO family: register map, edge-type encodings,
// and the counter-sizing helpers used by the debounce logic.
// Contents: ADDR_* register offsets, edge_type_e, clog2(), cnt_width().
package de1_blinker_pio_pkg;

  // Avalon-MM register offsets (word addresses)
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Which debounced transition sets a bit in edgecapture
  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Debounce counter width: clog2 of the hold time, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchroniser followed by a hold-time debounce filter.
// Latency: an input change held from edge k is reflected on deb_o at edge k+1+DEBOUNCE_CYCLES.
// Backpressure: none; free-running per clk.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   in_i           asynchronous board input
//   deb_o          debounced level (registered)
//   deb_chg_o      high for the one cycle before the edge on which deb_o toggles
module pio_debounce_bit
  import de1_blinker_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic deb_o,
  output logic deb_chg_o
);

  localparam int              CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter runs only while the synchronised input disagrees with the accepted
  // level; any agreement (a glitch ending) restarts the hold period from zero.
  always_comb begin
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    accept = 1'b0;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d  = sync2_q;
      cnt_d  = '0;
      accept = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign deb_o     = deb_q;
  // Combinational so edge capture in the parent registers on the same edge as deb_q.
  assign deb_chg_o = accept;

endmodule

// File: rtl/de1_blinker_input_pio.sv
// Avalon-MM input PIO: debounced board inputs, sticky edge capture, maskable level irq.
// Latency: reads are combinational (zero wait states); writes land on the strobe edge.
// Backpressure: none; the slave never stalls the interconnect.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   address, chipselect, write_n,     Avalon-MM slave write/select; reads need no strobe
//   writedata, readdata
//   in_port                           asynchronous keys/switches
//   irq                               high while any unmasked captured edge is pending
module de1_blinker_input_pio
  import de1_blinker_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_chg;
  logic [WIDTH-1:0] edge_ev;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic             wr_en;
  logic             writedata_unused;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_i     (in_port[i]),
      .deb_o    (deb[i]),
      .deb_chg_o(deb_chg[i])
    );
  end

  // deb still holds the old level while deb_chg is high, so the old level gives the
  // direction: old 0 means a rise, old 1 means a fall.
  always_comb begin
    edge_ev = deb_chg;
    if (EDGE_TYPE == int'(EDGE_RISING)) begin
      edge_ev = deb_chg & ~deb;
    end else if (EDGE_TYPE == int'(EDGE_FALLING)) begin
      edge_ev = deb_chg & deb;
    end
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    irqmask_d = irqmask_q;
    clr_mask  = '0;
    if (wr_en && (address == ADDR_IRQMASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGECAP)) begin
      clr_mask = writedata[WIDTH-1:0];
    end
    // Set is OR'd in after the clear so a fresh edge survives a same-cycle clear.
    edgecap_d = (edgecap_q & ~clr_mask) | edge_ev;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = deb;
      ADDR_RSVD:    readdata            = '0;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
      default:      readdata            = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

  // Upper writedata bits have no storage behind them.
  assign writedata_unused = ^writedata;

endmodule

// File: tb/tb_de1_blinker_input_pio.sv
// Scoreboard bench: three DUTs (rising / falling / any) share one stimulus stream.
module tb_de1_blinker_input_pio;

  localparam int W   = 4;
  localparam int DEB = 4;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] rdata [3];
  logic        irq_w [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    de1_blinker_input_pio #(
      .WIDTH(W), .EDGE_TYPE(g), .DEBOUNCE_CYCLES(DEB)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .in_port   (in_port),
      .readdata  (rdata[g]),
      .irq       (irq_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // An input level is accepted once the synchronised input has disagreed with the
  // accepted level for DEB consecutive edges; sync2 seen at edge n is in_port from edge n-2.
  logic [W-1:0]       inp_hist [$];
  logic [W-1:0]       seen     [$];
  logic [W-1:0]       m_deb, m_nd, m_rise, m_fall, m_ev, m_clr, m_s2;
  logic [W-1:0]       m_mask;
  logic [2:0][W-1:0]  m_cap;
  logic               m_hold;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_deb    = '0;
      m_mask   = '0;
      m_cap    = '0;
      inp_hist = '{4'h0, 4'h0};
      seen.delete();
    end else begin
      m_s2 = inp_hist.pop_front();
      inp_hist.push_back(in_port);
      seen.push_back(m_s2);
      if (seen.size() > DEB) void'(seen.pop_front());
      m_nd = m_deb;
      for (int b = 0; b < W; b++) begin
        m_hold = (seen.size() == DEB);
        foreach (seen[j]) if (seen[j][b] == m_deb[b]) m_hold = 1'b0;
        if (m_hold) m_nd[b] = ~m_deb[b];
      end
      m_rise = m_nd & ~m_deb;
      m_fall = ~m_nd & m_deb;
      m_clr  = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int d = 0; d < 3; d++) begin
        m_ev     = (d == 0) ? m_rise : (d == 1) ? m_fall : (m_rise | m_fall);
        m_cap[d] = (m_cap[d] & ~m_clr) | m_ev;
      end
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      m_deb = m_nd;
    end
  end

  function automatic logic [31:0] exp_rd(input int d, input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_deb);
      2'd2:    return 32'(m_mask);
      2'd3:    return 32'(m_cap[d]);
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0]        addr;
    logic [2:0][31:0]  rd;
    logic [2:0]        irq;
  } exp_t;

  exp_t exp_q [$];
  exp_t m_e;
  logic rd_vld;
  logic done;
  int   n_chk;
  int   n_fail;

  always @(negedge clk) begin
    if (done) begin
      n_chk++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end else if (rd_vld) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL underflow: read presented with empty scoreboard at %0t", $time);
      end else begin
        m_e = exp_q.pop_front();
        for (int d = 0; d < 3; d++) begin
          n_chk++;
          if (rdata[d] !== m_e.rd[d]) begin
            n_fail++;
            $display("FAIL readdata edge_type=%0d addr=%0d t=%0t: got %h required %h",
                     d, m_e.addr, $time, rdata[d], m_e.rd[d]);
          end
          n_chk++;
          if (irq_w[d] !== m_e.irq[d]) begin
            n_fail++;
            $display("FAIL irq edge_type=%0d t=%0t: got %b required %b",
                     d, $time, irq_w[d], m_e.irq[d]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] cur_in;
  logic         cur_rst;

  task automatic step(input logic [1:0] a, input bit wr, input logic [31:0] wd, input bit cs);
    exp_t e;
    @(posedge clk);
    #2;
    reset_n    = cur_rst;
    in_port    = cur_in;
    address    = a;
    writedata  = wd;
    write_n    = !wr;
    chipselect = cs;
    #1;
    rd_vld = !(cs && wr);
    if (rd_vld) begin
      e.addr = a;
      for (int d = 0; d < 3; d++) begin
        e.rd[d]  = exp_rd(d, a);
        e.irq[d] = |(m_cap[d] & m_mask);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic rd(input logic [1:0] a);
    step(a, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    step(a, 1'b1, wd, 1'b1);
  endtask

  task automatic hold(input logic [W-1:0] v, input int n);
    cur_in = v;
    for (int i = 0; i < n; i++) rd(2'((i % 2 == 0) ? 0 : 3));
  endtask

  initial begin
    reset_n = 1'b0; in_port = '0; address = '0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0; rd_vld = 1'b0; done = 1'b0;
    n_chk = 0; n_fail = 0; cur_in = '0; cur_rst = 1'b0;
    repeat (3) @(posedge clk);

    // reset state, then after release
    for (int a = 0; a < 4; a++) rd(2'(a));
    cur_rst = 1'b1;
    for (int a = 0; a < 4; a++) rd(2'(a));

    // 0 -> 5, data read every cycle across the acceptance edge
    cur_in = 4'h5;
    for (int i = 0; i < 8; i++) rd(2'd0);
    rd(2'd3);

    // mask and write-1-to-clear
    wr(2'd2, 32'h1);  rd(2'd3);
    wr(2'd3, 32'h1);  rd(2'd3);
    wr(2'd3, 32'h0);  rd(2'd3);
    rd(2'd2);

    // glitch too short, then one just long enough
    hold(4'h7, 3);  hold(4'h5, 10);
    hold(4'h7, 4);  hold(4'h5, 10);

    // bit 2 rise lands on the same edge as a clear of bit 2
    hold(4'h1, 10);
    wr(2'd3, 32'hF);
    cur_in = 4'h5;
    rd(2'd3);
    for (int i = 0; i < 4; i++) rd(2'd0);
    wr(2'd3, 32'h4);
    rd(2'd3); rd(2'd3);

    // bit 0 fall (captures on falling / any DUTs)
    hold(4'h4, 10);
    rd(2'd3);

    // reset in the middle of a debounce window
    hold(4'hB, 3);
    cur_rst = 1'b0;
    rd(2'd0); rd(2'd3); rd(2'd2);
    cur_rst = 1'b1;
    hold(4'hB, 10);

    // randomized traffic
    begin
      int run;
      int op;
      run = 0;
      for (int it = 0; it < 1500; it++) begin
        if (run == 0) begin
          cur_in = 4'($urandom_range(0, 15));
          run    = $urandom_range(1, 7);
        end
        run--;
        cur_rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
        op = $urandom_range(0, 9);
        case (op)
          0, 1:    wr(2'd2, $urandom());
          2, 3:    wr(2'd3, $urandom());
          4:       step(2'($urandom_range(0, 3)), 1'b1, $urandom(), 1'b0);
          5:       wr(2'($urandom_range(0, 1)), $urandom());
          default: rd(2'($urandom_range(0, 3)));
        endcase
      end
    end

    cur_rst = 1'b1;
    @(posedge clk);
    #2;
    rd_vld = 1'b0;
    @(posedge clk);
    #2;
    done = 1'b1;
  end

endmodule
